// File: rtl/vertex_edge_sequencer.sv
// Vertex fetcher / edge sequencer: loads one shape from vertex RAM, then streams its edges.
// Define VSEQ_OFFSET_EN to add x_off/y_off inputs that translate every vertex (mod 2^CW).
module vertex_edge_sequencer #(
    parameter int CW     = 10,
    parameter int VMAX   = 8,
    parameter int SHAPES = 8,
    localparam int SW    = $clog2(SHAPES),
    localparam int VW    = $clog2(VMAX),
    localparam int AW    = SW + VW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [SW-1:0] shape_sel,
    input  logic [VW:0]   vcount,
    input  logic          closed,
`ifdef VSEQ_OFFSET_EN
    input  logic [CW-1:0] x_off,
    input  logic [CW-1:0] y_off,
`endif
    output logic [AW-1:0] rd_addr,
    input  logic [CW-1:0] rd_data,
    output logic          busy,
    output logic          edge_valid,
    input  logic          edge_ready,
    output logic [CW-1:0] ex0,
    output logic [CW-1:0] ey0,
    output logic [CW-1:0] ex1,
    output logic [CW-1:0] ey1,
    output logic          edge_last,
    output logic          done,
    output logic          err
);
    localparam logic [VW:0] VMAX_C = (VW+1)'(VMAX);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_EMIT, S_DONE} state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [VW:0]   r_flast;
    logic [VW-1:0] r_nm1;
    logic [VW-1:0] r_lastk;
    logic [VW-1:0] r_k;
    logic          r_cap_en;
    logic [VW:0]   r_cap_idx;
    logic          r_busy, r_valid, r_last, r_done, r_err;
    logic [CW-1:0] r_ex0, r_ey0, r_ex1, r_ey1;
    logic [CW-1:0] r_vx [VMAX];
    logic [CW-1:0] r_vy [VMAX];

    logic          w_legal;
    logic [VW-1:0] w_ld_idx;
    logic [VW-1:0] w_ld_nxt;
    logic [CW-1:0] w_xoff, w_yoff;

`ifdef VSEQ_OFFSET_EN
    logic [CW-1:0] r_xoff, r_yoff;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xoff <= '0;
            r_yoff <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_xoff <= x_off;
            r_yoff <= y_off;
        end
    end
    assign w_xoff = r_xoff;
    assign w_yoff = r_yoff;
`else
    assign w_xoff = '0;
    assign w_yoff = '0;
`endif

    assign w_legal  = (vcount >= (VW+1)'(2)) && (vcount <= VMAX_C);
    // Edge to present next: 0 on entry to EMIT, otherwise the one after the current edge.
    assign w_ld_idx = r_valid ? r_k + 1'b1 : '0;
    assign w_ld_nxt = (w_ld_idx == r_nm1) ? '0 : w_ld_idx + 1'b1;

    // RAM data lags its address by one cycle; even addresses are x, odd are y.
    always_ff @(posedge clk) begin
        if (r_cap_en) begin
            if (r_cap_idx[0])
                r_vy[r_cap_idx[VW:1]] <= rd_data + w_yoff;
            else
                r_vx[r_cap_idx[VW:1]] <= rd_data + w_xoff;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_flast   <= '0;
            r_nm1     <= '0;
            r_lastk   <= '0;
            r_k       <= '0;
            r_cap_en  <= 1'b0;
            r_cap_idx <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ex0     <= '0;
            r_ey0     <= '0;
            r_ex1     <= '0;
            r_ey1     <= '0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cap_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_legal) begin
                            r_addr  <= {shape_sel, {VW{1'b0}}, 1'b0};
                            r_flast <= {VW'(vcount - 1'b1), 1'b1};
                            r_nm1   <= VW'(vcount - 1'b1);
                            r_lastk <= VW'(vcount - (VW+1)'(2) + {{VW{1'b0}}, closed});
                            r_busy  <= 1'b1;
                            r_state <= S_FETCH;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    r_cap_en  <= 1'b1;
                    r_cap_idx <= r_addr[VW:0];
                    // Hold on the last address so slot SHAPES-1 never wraps to slot 0.
                    if (r_addr[VW:0] == r_flast)
                        r_state <= S_DRAIN;
                    else
                        r_addr <= r_addr + 1'b1;
                end
                S_DRAIN: r_state <= S_EMIT;
                S_EMIT: begin
                    if (!r_valid || (edge_ready && !r_last)) begin
                        r_k     <= w_ld_idx;
                        r_ex0   <= r_vx[w_ld_idx];
                        r_ey0   <= r_vy[w_ld_idx];
                        r_ex1   <= r_vx[w_ld_nxt];
                        r_ey1   <= r_vy[w_ld_nxt];
                        r_last  <= (w_ld_idx == r_lastk);
                        r_valid <= 1'b1;
                    end else if (edge_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_addr    = r_addr;
    assign busy       = r_busy;
    assign edge_valid = r_valid;
    assign edge_last  = r_last;
    assign done       = r_done;
    assign err        = r_err;
    assign ex0        = r_ex0;
    assign ey0        = r_ey0;
    assign ex1        = r_ex1;
    assign ey1        = r_ey1;

endmodule

// File: tb/tb_vertex_edge_sequencer.sv
// Randomised bench for vertex_edge_sequencer: a cycle-level behavioural model plus directed literal pins.
module tb_vertex_edge_sequencer;
    localparam int CW = 10, VMAX = 8, SHAPES = 8, SW = 3, VW = 3, AW = 7;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, closed = 1'b0, edge_ready = 1'b0;
    logic [SW-1:0] shape_sel = '0;
    logic [VW:0]   vcount = '0;
    logic [CW-1:0] x_off = '0, y_off = '0;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data = '0;
    logic          busy, edge_valid, edge_last, done, err;
    logic [CW-1:0] ex0, ey0, ex1, ey1;
    logic [CW-1:0] mem [2**AW];

    vertex_edge_sequencer #(.CW(CW), .VMAX(VMAX), .SHAPES(SHAPES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .shape_sel(shape_sel), .vcount(vcount),
        .closed(closed),
`ifdef VSEQ_OFFSET_EN
        .x_off(x_off), .y_off(y_off),
`endif
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .edge_valid(edge_valid),
        .edge_ready(edge_ready), .ex0(ex0), .ey0(ey0), .ex1(ex1), .ey1(ey1),
        .edge_last(edge_last), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rd_data <= mem[rd_addr];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nerr = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [4*CW:0] pk(input int a, input int b, input int c, input int d, input bit l);
        return {CW'(a), CW'(b), CW'(c), CW'(d), l};
    endfunction

    function automatic logic [CW-1:0] vtx(input logic [AW-1:0] base, input int i, input bit y);
        return mem[base + AW'(2*i + int'(y))] + (y ? y_off : x_off);
    endfunction

    // Behavioural model: a job accepted at edge m_s presents address base+d for d<2N,
    // shows its first edge at d=2N+2, then one edge per accepted handshake.
    bit              m_init = 0, m_act = 0, lat_seen = 1;
    int              m_s = 0, m_n = 2, m_e = 1, m_idx = 0;
    int              m_done_at = -1, m_err_at = -1, m_rst_at = -1, lat_obs = -1;
    int              done_cnt = 0, err_cnt = 0;
    logic [AW-1:0]   m_base = '0, m_hold = '0;
    logic [4*CW-1:0] m_edge [VMAX];
    logic [4*CW:0]   obs_q [$];
    int              rmode = 0;

    always @(negedge clk) begin
        int d;
        logic [AW-1:0] ea;
        d = cyc - m_s;
        if (m_init) begin
            chk("busy", 64'(busy), 64'(m_act && d >= 0));
            chk("edge_valid", 64'(edge_valid), 64'(m_act && d >= 2*m_n + 2));
            chk("done", 64'(done), 64'(cyc == m_done_at));
            chk("err", 64'(err), 64'(cyc == m_err_at));
            ea = (m_act && d >= 0) ? m_base + AW'(d < 2*m_n ? d : 2*m_n - 1) : m_hold;
            chk("rd_addr", 64'(rd_addr), 64'(ea));
            if (m_act && d >= 2*m_n + 2) begin
                chk("edge", 64'({ex0, ey0, ex1, ey1}), 64'(m_edge[m_idx]));
                chk("edge_last", 64'(edge_last), 64'(m_idx == m_e - 1));
            end
            if (cyc == m_rst_at)
                chk("reset_edge_regs", 64'({ex0, ey0, ex1, ey1, edge_last}), 64'(0));
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (edge_valid === 1'b1 && !lat_seen) begin
            lat_seen = 1;
            lat_obs  = d;
        end
        if (!rst_n) begin
            m_init = 1; m_act = 0; m_hold = '0;
            m_done_at = -1; m_err_at = -1; m_rst_at = cyc + 1;
        end else if (m_init) begin
            if (start && !m_act && cyc != m_done_at) begin
                if (vcount >= 2 && vcount <= VMAX) begin
                    m_act = 1; m_s = cyc + 1; m_n = int'(vcount); m_idx = 0;
                    m_e = m_n - 1 + int'(closed);
                    m_base = {shape_sel, {VW{1'b0}}, 1'b0};
                    m_hold = m_base + AW'(2*m_n - 1);
                    lat_seen = 0;
                    for (int k = 0; k < m_e; k++)
                        m_edge[k] = {vtx(m_base, k, 0), vtx(m_base, k, 1),
                                     vtx(m_base, (k+1) % m_n, 0), vtx(m_base, (k+1) % m_n, 1)};
                end else begin
                    m_err_at = cyc + 1;
                end
            end else if (m_act && d >= 2*m_n + 2 && edge_ready) begin
                obs_q.push_back({ex0, ey0, ex1, ey1, edge_last});
                m_idx++;
                if (m_idx == m_e) begin
                    m_act = 0;
                    m_done_at = cyc + 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0:       edge_ready = 1'b1;
            1:       edge_ready = ~edge_ready;
            default: edge_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic pulse_start(input int sh, input int n, input bit cl);
        obs_q.delete();
        shape_sel = SW'(sh); vcount = (VW+1)'(n); closed = cl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int sh, input int n, input bit cl);
        int d0;
        d0 = done_cnt;
        pulse_start(sh, n, cl);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
        chk("job_done_count", 64'(done_cnt - d0), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int d0, e0;
        logic [AW-1:0] a0;
        for (int i = 0; i < 2**AW; i++) mem[i] = CW'($urandom);
        for (int i = 0; i < 4; i++) begin
            mem[7'h30 + 2*i] = CW'(10 + i);
            mem[7'h31 + 2*i] = CW'(20 + i);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // shape 3, N=4, open, always ready
        rmode = 0;
        run_job(3, 4, 0);
        chk("lit_latency", 64'(lat_obs), 64'(10));
        chk("lit_nedges_open", 64'(obs_q.size()), 64'(3));
        chk("lit_edge0", 64'(obs_q[0]), 64'(pk(10, 20, 11, 21, 0)));
        chk("lit_edge2", 64'(obs_q[2]), 64'(pk(12, 22, 13, 23, 1)));
        chk("lit_last_addr", 64'(rd_addr), 64'(7'h37));

        // same shape closed, ready toggling
        rmode = 1;
        run_job(3, 4, 1);
        chk("lit_nedges_closed", 64'(obs_q.size()), 64'(4));
        chk("lit_closing_edge", 64'(obs_q[3]), 64'(pk(13, 23, 10, 20, 1)));

        // top slot, full shape, random ready
        rmode = 2;
        run_job(7, 8, 1);
        chk("lit_top_addr", 64'(rd_addr), 64'(7'h7F));
        chk("lit_nedges_full", 64'(obs_q.size()), 64'(8));

        // N=2 closed: second edge is the first reversed
        run_job(1, 2, 1);
        chk("lit_n2_count", 64'(obs_q.size()), 64'(2));
        chk("lit_n2_reverse", 64'(obs_q[1]),
            64'({obs_q[0][2*CW:CW+1], obs_q[0][CW:1], obs_q[0][4*CW:3*CW+1], obs_q[0][3*CW:2*CW+1], 1'b1}));

        // illegal vcounts
        e0 = err_cnt; a0 = rd_addr;
        pulse_start(2, 1, 0);
        repeat (3) @(posedge clk); #1;
        pulse_start(2, 9, 0);
        repeat (3) @(posedge clk); #1;
        chk("lit_err_pulses", 64'(err_cnt - e0), 64'(2));
        chk("lit_err_addr_kept", 64'(rd_addr), 64'(a0));

        // reset after second transfer abandons the shape
        rmode = 0;
        d0 = done_cnt;
        pulse_start(3, 4, 0);
        for (int i = 0; i < 100 && obs_q.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        chk("lit_two_transfers", 64'(obs_q.size()), 64'(2));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk); #1;
        chk("lit_no_done_after_reset", 64'(done_cnt - d0), 64'(0));
        run_job(3, 4, 0);
        chk("lit_restart_edge2", 64'(obs_q[2]), 64'(pk(12, 22, 13, 23, 1)));

`ifdef VSEQ_OFFSET_EN
        x_off = CW'(1020); y_off = CW'(5);
        run_job(3, 4, 0);
        chk("lit_off_ex0", 64'(obs_q[0][4*CW:3*CW+1]), 64'(6));
        chk("lit_off_ey0", 64'(obs_q[0][3*CW:2*CW+1]), 64'(25));
        x_off = '0; y_off = '0;
`endif

        // random traffic, including starts while busy and occasional resets
        rmode = 2;
        for (int c = 0; c < 5000; c++) begin
            start     = ($urandom_range(0, 5) == 0);
            shape_sel = SW'($urandom);
            vcount    = ($urandom_range(0, 7) == 0) ? (VW+1)'($urandom_range(0, VMAX + 1))
                                                     : (VW+1)'($urandom_range(2, VMAX));
            closed    = 1'($urandom_range(0, 1));
`ifdef VSEQ_OFFSET_EN
            x_off     = CW'($urandom);
            y_off     = CW'($urandom);
`endif
            rst_n     = ($urandom_range(0, 799) != 0);
            @(posedge clk); #1;
        end
        start = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 300 && m_act; i++) @(posedge clk);
        chk("drain_timeout", 64'(m_act), 64'(0));
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/vertex_edge_sequencer.md
# vertex_edge_sequencer

Parametrised vertex fetcher and edge sequencer for the vector-display pipeline. It reads up to VMAX vertices of a selected shape from the synchronous vertex RAM using back-to-back pipelined reads. It then streams the polyline or closed polygon as one edge at a time to the line drawer over a valid/ready handshake. It sits between the game/shape control logic and the line rasteriser, replacing the fixed four-vertex loader.

## Interface
- CW, 10: coordinate width in bits.
- VMAX, 8: maximum vertices per shape; power of two, ≥2.
- SHAPES, 8: number of shape slots; power of two. SW = log2(SHAPES), VW = log2(VMAX), AW = SW+VW+1.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low; clock clk.
- start  in  1  load request; sampled only in IDLE.
- shape_sel  in  SW  shape slot to load.
- vcount  in  VW+1  vertices in shape; legal 2..VMAX.
- closed  in  1  1 = also emit closing edge v[N-1]->v[0].
- rd_addr  out  AW  RAM read address, registered; x_i at {shape,i,0}, y_i at {shape,i,1}.
- rd_data  in  CW  RAM read data, valid the cycle after rd_addr is presented.
- busy  out  1  high from start acceptance until done.
- edge_valid  out  1  edge on ex0..ey1 is valid.
- edge_ready  in  1  line drawer accepts edge.
- ex0, ey0, ex1, ey1  out  CW each  edge start/end coordinates.
- edge_last  out  1  qualifies final edge of shape.
- done  out  1  one-cycle pulse after final edge transfer.
- err  out  1  one-cycle pulse on illegal vcount.

## Operation
- States: IDLE, FETCH, DRAIN, EMIT, DONE.
- IDLE: start=1 with legal vcount captures shape_sel, vcount (N), closed; rd_addr <= {shape,0,0}; busy <= 1; -> FETCH. Illegal vcount (<2 or >VMAX): err pulses next cycle, no reads, stay IDLE.
- FETCH: rd_addr increments by 1 each cycle, 2N addresses total. rd_data is captured into the vertex buffer one cycle after each address, in address order. After the last address -> DRAIN.
- DRAIN: captures final y[N-1] -> EMIT with edge index 0.
- EMIT: edge k = v[k]->v[k+1] for k=0..N-2. If closed, adds edge N-1 = v[N-1]->v[0]. Total edges E = N-1+closed. edge_last=1 on edge E-1.
- Transfer occurs when edge_valid&&edge_ready. Next edge is presented the following cycle with edge_valid held high, so back-to-back transfers run at 1 edge/cycle. After the last transfer -> DONE.
- DONE: done=1 and busy=0 for one cycle -> IDLE.
- start is ignored while busy.
- Vertex buffer holds VMAX×2 CW-bit entries; unused entries are don't-care.
- Reset values: state IDLE, rd_addr 0, busy 0, edge_valid 0, edge_last 0, done 0, err 0, ex0..ey1 0.

## Timing
- Start sampled at edge E0 gives first edge_valid high after edge E(2N+2); N=4 → 10 cycles.
- While edge_valid=1 and edge_ready=0: ex0..ey1 and edge_last are held stable, and edge_valid must not drop.
- edge_ready high while edge_valid=0 has no effect.
- N=2, closed=1: two edges, v0->v1 then v1->v0.
- Shape slot SHAPES-1 with N=VMAX reads the top address 2^AW-1 and does not wrap into slot 0.
- rst_n low in any state: IDLE and all outputs at reset values on the next edge; a partially emitted shape is abandoned and no done pulse is produced.
- done and a new start in the same cycle: start is ignored because the block is not yet in IDLE.

## Configuration
- VSEQ_OFFSET_EN defined: adds inputs x_off, y_off (CW each), sampled with start. Each coordinate is stored as rd_data + offset, modulo 2^CW (wraps, no saturation).
- VSEQ_OFFSET_EN undefined: ports absent; coordinates are passed through unmodified.

## Test plan
- Shape 3, N=4, closed=0, RAM at {3,i,0/1} = x 10+i, y 20+i, edge_ready=1 -> rd_addr 0x30..0x37 on consecutive cycles; edges (10,20)->(11,21), (11,21)->(12,22), (12,22)->(13,23) on back-to-back cycles; edge_last on the 3rd edge; done one cycle later; first edge_valid 10 cycles after start.
- Same shape, closed=1, edge_ready toggling 0/1 -> 4 edges, 4th is (13,23)->(10,20) with edge_last; outputs stable during ready=0 cycles.
- Shape 7, N=8, closed=1 -> 16 reads ending at rd_addr 0x7F; 8 edges; no wrap to slot 0.
- vcount=1, then vcount=9 -> err pulse each time, rd_addr unchanged, busy stays 0, no edge_valid.
- rst_n low for one cycle during EMIT after the 2nd transfer -> all outputs 0 next cycle, no done; a fresh start then completes normally.
- With VSEQ_OFFSET_EN, x_off=1020, y_off=5, x=10 -> first ex0=6 (1030 mod 1024), ey0=25.
